// File: rtl/pgr_apb_mst_32bit.sv
// APB3/APB4 master for the UART debug channel.
// Takes one parsed command, runs a single APB transfer with a pready
// watchdog, and on reads streams the result back LSB byte first.
module pgr_apb_mst_32bit #(
    parameter int          AW           = 16,
    parameter int          DW           = 32,
    parameter int          SW           = 4,
    parameter int          TIMEOUT_CYC  = 1024,
    parameter logic [31:0] TIMEOUT_DATA = 32'hDEAD_BEEF
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          cmd_en,
    input  logic          we,
    input  logic [AW-1:0] addr,
    input  logic [DW-1:0] wdata,
    input  logic [SW-1:0] strb,
    input  logic          strb_en,
    output logic          cmd_done,
    output logic          apb_psel,
    output logic          apb_penable,
    output logic          apb_pwrite,
    output logic [AW-1:0] apb_paddr,
    output logic [DW-1:0] apb_pwdata,
    output logic [SW-1:0] apb_pstrb,
    input  logic [DW-1:0] apb_prdata,
    input  logic          apb_pready,
    input  logic          apb_pslverr,
    output logic [7:0]    tx_data,
    output logic          tx_valid,
    input  logic          tx_ready,
    output logic          err_flag,
    output logic          busy
);

    localparam int            NBYTE    = DW / 8;
    localparam int            IW       = (NBYTE > 1) ? $clog2(NBYTE) : 1;
    localparam logic [IW-1:0] LAST_IDX = IW'(NBYTE - 1);
    localparam logic [15:0]   WDOG_MAX = 16'(TIMEOUT_CYC - 1);
    localparam logic [DW-1:0] TO_DATA  = TIMEOUT_DATA[DW-1:0];

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_SETUP,
        ST_ACCESS,
        ST_RESP,
        ST_DONE
    } state_t;

    state_t          state_reg;
    logic            psel_reg;
    logic            penable_reg;
    logic            pwrite_reg;
    logic [AW-1:0]   paddr_reg;
    logic [DW-1:0]   pwdata_reg;
    logic [SW-1:0]   pstrb_reg;
    logic [DW-1:0]   rdata_reg;
    logic [15:0]     wdog_reg;
    logic [IW-1:0]   idx_reg;
    logic [7:0]      tx_data_reg;
    logic            tx_valid_reg;
    logic            cmd_done_reg;
    logic            err_flag_reg;
    logic            busy_reg;

    // Read data that ACCESS would latch this cycle: slave data, or the
    // timeout marker when the watchdog gives up.
    logic [DW-1:0]   rdata_next;
    logic [IW-1:0]   idx_next;
    logic [7:0]      rd_byte [NBYTE];

    assign rdata_next = apb_pready ? apb_prdata : TO_DATA;
    assign idx_next   = idx_reg + IW'(1);

    genvar gi;
    generate
        for (gi = 0; gi < NBYTE; gi++) begin : g_byte
            assign rd_byte[gi] = rdata_reg[gi*8 +: 8];
        end
    endgenerate

    // Transfer sequencer; every output is a register updated on transitions.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg    <= ST_IDLE;
            psel_reg     <= 1'b0;
            penable_reg  <= 1'b0;
            pwrite_reg   <= 1'b0;
            paddr_reg    <= '0;
            pwdata_reg   <= '0;
            pstrb_reg    <= '0;
            rdata_reg    <= '0;
            wdog_reg     <= '0;
            idx_reg      <= '0;
            tx_data_reg  <= '0;
            tx_valid_reg <= 1'b0;
            cmd_done_reg <= 1'b0;
            err_flag_reg <= 1'b0;
            busy_reg     <= 1'b0;
        end else begin
            case (state_reg)
                ST_IDLE: begin
                    cmd_done_reg <= 1'b0;
                    if (cmd_en) begin
                        psel_reg    <= 1'b1;
                        penable_reg <= 1'b0;
                        pwrite_reg  <= we;
                        paddr_reg   <= addr;
                        pwdata_reg  <= wdata;
                        pstrb_reg   <= we ? (strb_en ? strb : '1) : '0;
                        busy_reg    <= 1'b1;
                        state_reg   <= ST_SETUP;
                    end
                end
                ST_SETUP: begin
                    penable_reg <= 1'b1;
                    wdog_reg    <= '0;
                    state_reg   <= ST_ACCESS;
                end
                ST_ACCESS: begin
                    wdog_reg <= wdog_reg + 16'd1;
                    // pready has priority over an expiring watchdog
                    if (apb_pready || (wdog_reg == WDOG_MAX)) begin
                        err_flag_reg <= apb_pready ? apb_pslverr : 1'b1;
                        psel_reg     <= 1'b0;
                        penable_reg  <= 1'b0;
                        pwrite_reg   <= 1'b0;
                        paddr_reg    <= '0;
                        pwdata_reg   <= '0;
                        pstrb_reg    <= '0;
                        if (pwrite_reg) begin
                            cmd_done_reg <= 1'b1;
                            state_reg    <= ST_DONE;
                        end else begin
                            rdata_reg    <= rdata_next;
                            idx_reg      <= '0;
                            tx_data_reg  <= rdata_next[7:0];
                            tx_valid_reg <= 1'b1;
                            state_reg    <= ST_RESP;
                        end
                    end
                end
                ST_RESP: begin
                    // tx_data only moves on a handshake, so it is stable while stalled
                    if (tx_ready) begin
                        if (idx_reg == LAST_IDX) begin
                            tx_valid_reg <= 1'b0;
                            tx_data_reg  <= '0;
                            cmd_done_reg <= 1'b1;
                            state_reg    <= ST_DONE;
                        end else begin
                            idx_reg     <= idx_next;
                            tx_data_reg <= rd_byte[idx_next];
                        end
                    end
                end
                ST_DONE: begin
                    cmd_done_reg <= 1'b0;
                    busy_reg     <= 1'b0;
                    state_reg    <= ST_IDLE;
                end
                default: begin
                    state_reg <= ST_IDLE;
                end
            endcase
        end
    end

    assign apb_psel    = psel_reg;
    assign apb_penable = penable_reg;
    assign apb_pwrite  = pwrite_reg;
    assign apb_paddr   = paddr_reg;
    assign apb_pwdata  = pwdata_reg;
    assign apb_pstrb   = pstrb_reg;
    assign tx_data     = tx_data_reg;
    assign tx_valid    = tx_valid_reg;
    assign cmd_done    = cmd_done_reg;
    assign err_flag    = err_flag_reg;
    assign busy        = busy_reg;

endmodule

// File: tb/tb_pgr_apb_mst_32bit.sv
// Directed bench for pgr_apb_mst_32bit with a response-byte scoreboard.
module tb_pgr_apb_mst_32bit;

    localparam int AW = 16;
    localparam int DW = 32;
    localparam int SW = 4;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          cmd_en = 1'b0;
    logic          we = 1'b0;
    logic [AW-1:0] addr = '0;
    logic [DW-1:0] wdata = '0;
    logic [SW-1:0] strb = '0;
    logic          strb_en = 1'b1;
    logic          cmd_done;
    logic          apb_psel;
    logic          apb_penable;
    logic          apb_pwrite;
    logic [AW-1:0] apb_paddr;
    logic [DW-1:0] apb_pwdata;
    logic [SW-1:0] apb_pstrb;
    logic [DW-1:0] apb_prdata = '0;
    logic          apb_pready = 1'b1;
    logic          apb_pslverr = 1'b0;
    logic [7:0]    tx_data;
    logic          tx_valid;
    logic          tx_ready = 1'b1;
    logic          err_flag;
    logic          busy;

    int total = 0;
    int bad   = 0;
    logic [7:0] exp_q [$];

    pgr_apb_mst_32bit #(
        .AW(AW), .DW(DW), .SW(SW),
        .TIMEOUT_CYC(8), .TIMEOUT_DATA(32'hDEAD_BEEF)
    ) dut (
        .clk(clk), .rst(rst), .cmd_en(cmd_en), .we(we), .addr(addr),
        .wdata(wdata), .strb(strb), .strb_en(strb_en), .cmd_done(cmd_done),
        .apb_psel(apb_psel), .apb_penable(apb_penable), .apb_pwrite(apb_pwrite),
        .apb_paddr(apb_paddr), .apb_pwdata(apb_pwdata), .apb_pstrb(apb_pstrb),
        .apb_prdata(apb_prdata), .apb_pready(apb_pready), .apb_pslverr(apb_pslverr),
        .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready),
        .err_flag(err_flag), .busy(busy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Drive one command for a single cycle; expected bytes go in the scoreboard for reads.
    task automatic issue(input logic w, input logic [AW-1:0] a, input logic [DW-1:0] d,
                         input logic [SW-1:0] s, input logic [DW-1:0] exp_rd);
        cmd_en = 1'b1; we = w; addr = a; wdata = d; strb = s;
        if (!w) begin
            for (int b = 0; b < DW/8; b++) exp_q.push_back(exp_rd[b*8 +: 8]);
        end
        step();
        cmd_en = 1'b0;
        $display("cmd %s addr=%h wdata=%h strb=%h", w ? "WR" : "RD", a, d, s);
    endtask

    task automatic wait_done(input string tag);
        int n = 0;
        while (!cmd_done && n < 60) begin
            step();
            n++;
        end
        chk(tag, {31'd0, cmd_done}, 32'd1);
    endtask

    // Scoreboard side: every accepted byte must match the next expected one,
    // and tx_data must hold while a byte is stalled.
    logic       stall_prev = 1'b0;
    logic [7:0] data_prev  = '0;
    always @(negedge clk) begin
        if (!rst) begin
            if (stall_prev && tx_valid)
                chk("tx_hold", {24'd0, tx_data}, {24'd0, data_prev});
            if (tx_valid && tx_ready) begin
                if (exp_q.size() == 0) begin
                    chk("tx_unexpected", {24'd0, tx_data}, 32'hFFFF_FFFF);
                end else begin
                    logic [7:0] e;
                    e = exp_q.pop_front();
                    chk("tx_byte", {24'd0, tx_data}, {24'd0, e});
                    $display("tx byte %h (expected %h)", tx_data, e);
                end
            end
            stall_prev = tx_valid && !tx_ready;
            data_prev  = tx_data;
        end else begin
            stall_prev = 1'b0;
        end
    end

    initial begin
        int cnt;
        logic done;

        // Reset state
        step();
        chk("rst_psel", {31'd0, apb_psel}, 32'd0);
        chk("rst_busy", {31'd0, busy}, 32'd0);
        chk("rst_txv", {31'd0, tx_valid}, 32'd0);
        chk("rst_done", {31'd0, cmd_done}, 32'd0);
        rst = 1'b0;
        step();

        // 1: zero-wait write with strobes
        apb_pready = 1'b1; strb_en = 1'b1;
        issue(1'b1, 16'h0010, 32'h1234_5678, 4'h3, '0);
        chk("w1_psel", {31'd0, apb_psel}, 32'd1);
        chk("w1_pen0", {31'd0, apb_penable}, 32'd0);
        chk("w1_pstrb", {28'd0, apb_pstrb}, 32'h3);
        chk("w1_paddr", {16'd0, apb_paddr}, 32'h0010);
        chk("w1_pwdata", apb_pwdata, 32'h1234_5678);
        chk("w1_pwrite", {31'd0, apb_pwrite}, 32'd1);
        chk("w1_busy", {31'd0, busy}, 32'd1);
        step();
        chk("w1_pen1", {31'd0, apb_penable}, 32'd1);
        chk("w1_paddr_hold", {16'd0, apb_paddr}, 32'h0010);
        step();
        chk("w1_done", {31'd0, cmd_done}, 32'd1);
        chk("w1_psel_drop", {31'd0, apb_psel}, 32'd0);
        chk("w1_paddr_drop", {16'd0, apb_paddr}, 32'd0);
        chk("w1_err", {31'd0, err_flag}, 32'd0);
        step();
        chk("w1_done_pulse", {31'd0, cmd_done}, 32'd0);
        chk("w1_idle", {31'd0, busy}, 32'd0);

        // 2: zero-wait read, tx_ready high
        apb_prdata = 32'hA1B2_C3D4; tx_ready = 1'b1;
        issue(1'b0, 16'h0020, '0, 4'hF, 32'hA1B2_C3D4);
        chk("r2_pstrb", {28'd0, apb_pstrb}, 32'd0);
        chk("r2_pwrite", {31'd0, apb_pwrite}, 32'd0);
        step();
        chk("r2_pen", {31'd0, apb_penable}, 32'd1);
        for (int i = 0; i < 4; i++) begin
            step();
            chk("r2_txv", {31'd0, tx_valid}, 32'd1);
        end
        step();
        chk("r2_done", {31'd0, cmd_done}, 32'd1);
        chk("r2_txv_low", {31'd0, tx_valid}, 32'd0);
        step();

        // 3: read with 5 wait states and a stalling TX FIFO
        apb_pready = 1'b0; apb_prdata = 32'h0BAD_F00D;
        issue(1'b0, 16'h0030, '0, 4'h0, 32'h1122_3344);
        cnt = 0;
        for (int i = 0; i < 6; i++) begin
            step();
            if (apb_penable) cnt++;
            if (i == 5) begin
                apb_pready = 1'b1;
                apb_prdata = 32'h1122_3344;
            end
        end
        chk("r3_pen_cycles", cnt, 32'd6);
        tx_ready = 1'b0;
        step();
        apb_prdata = 32'h5566_7788;
        chk("r3_pen_drop", {31'd0, apb_penable}, 32'd0);
        done = 1'b0;
        for (int k = 0; k < 40 && !done; k++) begin
            step();
            if (cmd_done) done = 1'b1;
            tx_ready = ~tx_ready;
        end
        chk("r3_done", {31'd0, done}, 32'd1);
        tx_ready = 1'b1;
        step();

        // 4: write with strobes disabled
        strb_en = 1'b0;
        issue(1'b1, 16'h0040, 32'hCAFE_0001, 4'h0, '0);
        chk("w4_pstrb", {28'd0, apb_pstrb}, 32'hF);
        wait_done("w4_done");
        strb_en = 1'b1;
        step();

        // 5: read against a hung slave
        apb_pready = 1'b0;
        issue(1'b0, 16'h0050, '0, 4'h0, 32'hDEAD_BEEF);
        cnt = 0;
        for (int k = 0; k < 50; k++) begin
            step();
            if (apb_penable) cnt++;
            else break;
        end
        chk("r5_access_cycles", cnt, 32'd8);
        chk("r5_err", {31'd0, err_flag}, 32'd1);
        wait_done("r5_done");
        step();

        // 6: slave error on write, then a clean read clears it
        apb_pready = 1'b1; apb_pslverr = 1'b1;
        issue(1'b1, 16'h0060, 32'h0000_00AA, 4'hF, '0);
        wait_done("w6_done");
        chk("w6_err", {31'd0, err_flag}, 32'd1);
        apb_pslverr = 1'b0;
        step();
        apb_prdata = 32'h0102_0304;
        issue(1'b0, 16'h0064, '0, 4'h0, 32'h0102_0304);
        wait_done("r6_done");
        chk("r6_err", {31'd0, err_flag}, 32'd0);
        step();

        // 7: reset in the middle of ACCESS
        apb_pready = 1'b0;
        issue(1'b1, 16'h0070, 32'h7777_7777, 4'hF, '0);
        step();
        chk("x7_in_access", {31'd0, apb_penable}, 32'd1);
        rst = 1'b1;
        #1;
        chk("x7_psel_async", {31'd0, apb_psel}, 32'd0);
        chk("x7_busy_async", {31'd0, busy}, 32'd0);
        for (int k = 0; k < 3; k++) begin
            step();
            chk("x7_no_done", {31'd0, cmd_done}, 32'd0);
        end
        rst = 1'b0;
        apb_pready = 1'b1;
        for (int k = 0; k < 4; k++) begin
            step();
            chk("x7_quiet", {30'd0, cmd_done, apb_psel}, 32'd0);
        end

        chk("sb_empty", exp_q.size(), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
